timekeeper_bcd: RTL and testbench
=================================

Name: timekeeper_bcd

Overview:
- Upstream time source for the digital clock.
- Divides the 1 kHz system clock into a seconds tick and keeps BCD Hour/Minute/Second (24-hour).
- Provides debounced hour/minute adjust keys and a pause control.
- Its Hour, Minute and Second outputs feed the alarm comparator and the display directly.

Parameters:
- TICK_DIV, 1000: clock cycles per second tick.
- DEBOUNCE_CYC, 20: consecutive stable cycles needed to accept a key level change.

Ports:
- _1KHz  input  1  system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- AdjHour  input  1  raw hour-adjust key, asynchronous and bouncy, active-high.
- AdjMin  input  1  raw minute-adjust key, asynchronous and bouncy, active-high.
- Pause  input  1  high = timekeeping stopped; adjust keys still work.
- Hour  output  8  BCD hour, [7:4] tens, [3:0] units, 00–23.
- Minute  output  8  BCD minute, 00–59.
- Second  output  8  BCD second, 00–59.
- SecTick  output  1  one-cycle pulse on the cycle Second advances.
- Chime  output  1  hourly chime enable (see Optional Feature).

Behaviour:
- Interface: one clock (_1KHz); reset is synchronous and active-high (Reset).
- Reset (sampled high at a clock edge):
  - Hour=Minute=Second=8'h00, SecTick=0, Chime=0.
  - Prescaler=0, synchronizers and debounce stable states=0, pending adjust flags=0.
  - Reset mid-press: the key must be seen low-stable and then high-stable again before it counts.
- Prescaler:
  - Counts 0..TICK_DIV-1 while Pause=0; holds its value while Pause=1.
  - Internal tick asserts when the count is TICK_DIV-1 and Pause=0; the count wraps to 0.
  - Time registers update on the same edge that wraps the prescaler.
  - SecTick is registered and high exactly the cycle after that edge, together with the new Second value.
- Time arithmetic (BCD, each digit always valid):
  - Second units 9 -> 0 with tens carry; Second 59 -> 00 carries into Minute.
  - Minute 59 -> 00 carries into Hour.
  - Hour 23 -> 00; Hour 09 -> 10, 19 -> 20.
  - Full wrap: 23:59:59 -> 00:00:00 on one tick.
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced level differs from the stable state; it clears when they match.
  - When the counter reaches DEBOUNCE_CYC, the stable state takes the synced level and the counter clears.
  - A rising edge of the stable state sets that key's pending flag.
- Adjust application:
  - A pending flag is served on the first cycle with no internal tick: the field increments and the flag clears.
  - Minute adjust: 59 -> 00, no carry into Hour; Second untouched.
  - Hour adjust: 23 -> 00; Minute and Second untouched.
  - Hour and Minute adjusts pending together are applied on the same cycle.
- Coincident tick and pending adjust: the tick wins, and the adjust is applied on the next cycle. No increment is ever lost or doubled.
- Latency: with a clean key edge at cycle 0, the field changes at edge DEBOUNCE_CYC+3, provided no tick coincides.
- Holding a key: exactly one increment per press; there is no auto-repeat.
- Pause=1: Second, Minute and Hour frozen and SecTick=0. Resuming continues from the held prescaler value.

Optional Feature:
- Macro: HOURLY_CHIME_EN.
- Defined: Chime is registered high while Minute==8'h59 and Second>=8'h55 and Pause=0, i.e. 5 s before each hour. It drops on the cycle the time shows xx:00:00.
- Defined, adjust into the window: adjusting into the window raises Chime on the next cycle; adjusting out of it clears Chime on the next cycle.
- Undefined: Chime is constant 0 and no chime logic is synthesized.

Test Plan:
- Reset, then run 3*TICK_DIV cycles with Pause=0 -> Second 00->01->02->03; SecTick pulses exactly 3 times, TICK_DIV cycles apart.
- Preload via adjusts plus ticks to 23:59:58, then run 2 ticks -> 23:59:59 then 00:00:00; the wrap happens in one cycle.
- AdjMin with 5 cycles of 0/1 bounce, then held high 100 cycles -> exactly one Minute increment at DEBOUNCE_CYC+3 after the last edge. Minute 59 -> 00 with Hour unchanged.
- Arrange for the AdjHour pending flag to set on the prescaler TICK_DIV-1 cycle -> Second advances on that edge and Hour increments on the following edge. Hour 09 -> 10 in BCD.
- Pause=1 for 2500 cycles mid-second, then Pause=0 -> no SecTick while paused; the next tick arrives after only the remaining prescaler count.
- With HOURLY_CHIME_EN defined, run from 12:59:50 -> Chime high from 12:59:55 through 12:59:59, low at 13:00:00. With the macro undefined -> Chime stays 0 throughout.

Source files
------------

// File: rtl/timekeeper_bcd.sv
// timekeeper_bcd: 24-hour BCD time-of-day source for the digital clock.
// Divides the 1 kHz clock into a seconds tick, keeps Hour/Minute/Second in BCD,
// and applies debounced hour/minute adjust keys. Pause freezes timekeeping.
// Optional build macro: HOURLY_CHIME_EN enables the hourly Chime output;
// when undefined, Chime is tied low and no chime logic exists.
`timescale 1ns/1ps
module timekeeper_bcd #(
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CYC = 20
) (
    input  logic       _1KHz,
    input  logic       Reset,
    input  logic       AdjHour,
    input  logic       AdjMin,
    input  logic       Pause,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic       SecTick,
    output logic       Chime
);

    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned KEY_MIN  = 0;
    localparam int unsigned KEY_HOUR = 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic [PRE_W-1:0] presc;
    logic             tick_c;

    logic [1:0]       key_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       armed;
    logic [1:0]       pend;
    logic [1:0]       key_rise_c;
    logic [DEB_W-1:0] deb_cnt [2];

    logic [7:0]       hour_nxt;
    logic [7:0]       min_nxt;
    logic [7:0]       sec_nxt;

    // Two-digit BCD increment that wraps to 00 after lim.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {4'(v[7:4] + 4'd1), 4'd0};
        end else begin
            r = {v[7:4], 4'(v[3:0] + 4'd1)};
        end
        return r;
    endfunction

    assign key_raw = {AdjHour, AdjMin};
    assign tick_c  = (presc == PRE_LAST) && !Pause;

    // Seconds prescaler; holds its count while paused.
    always_ff @(posedge _1KHz) begin
        if (Reset) begin
            presc <= '0;
        end else if (!Pause) begin
            if (tick_c) begin
                presc <= '0;
            end else begin
                presc <= presc + PRE_W'(1);
            end
        end
    end

    // Key synchronizers and debouncers. After reset a key must first be seen
    // low for the debounce time (armed) before a press can be accepted.
    always_ff @(posedge _1KHz) begin
        if (Reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            armed  <= '0;
            for (int k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                if (!armed[k]) begin
                    if (sync2[k]) begin
                        deb_cnt[k] <= '0;
                    end else if (deb_cnt[k] == DEB_LAST) begin
                        armed[k]   <= 1'b1;
                        deb_cnt[k] <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                    end
                end else if (sync2[k] == stable[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    stable[k]  <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced state, flagged on the edge it is accepted.
    always_comb begin
        key_rise_c = '0;
        for (int k = 0; k < 2; k++) begin
            key_rise_c[k] = armed[k] && !stable[k] && sync2[k] && (deb_cnt[k] == DEB_LAST);
        end
    end

    // Pending adjust flags: a tick cycle defers service, otherwise served at once.
    always_ff @(posedge _1KHz) begin
        if (Reset) begin
            pend <= '0;
        end else if (tick_c) begin
            pend <= pend | key_rise_c;
        end else begin
            pend <= key_rise_c;
        end
    end

    // Next time value: a tick has priority over pending adjusts.
    always_comb begin
        hour_nxt = Hour;
        min_nxt  = Minute;
        sec_nxt  = Second;
        if (tick_c) begin
            sec_nxt = bcd_inc(Second, 8'h59);
            if (Second == 8'h59) begin
                min_nxt = bcd_inc(Minute, 8'h59);
                if (Minute == 8'h59) begin
                    hour_nxt = bcd_inc(Hour, 8'h23);
                end
            end
        end else begin
            if (pend[KEY_MIN]) begin
                min_nxt = bcd_inc(Minute, 8'h59);
            end
            if (pend[KEY_HOUR]) begin
                hour_nxt = bcd_inc(Hour, 8'h23);
            end
        end
    end

    // Time registers and the seconds pulse.
    always_ff @(posedge _1KHz) begin
        if (Reset) begin
            Hour    <= 8'h00;
            Minute  <= 8'h00;
            Second  <= 8'h00;
            SecTick <= 1'b0;
        end else begin
            Hour    <= hour_nxt;
            Minute  <= min_nxt;
            Second  <= sec_nxt;
            SecTick <= tick_c;
        end
    end

`ifdef HOURLY_CHIME_EN
    // Chime follows the values being loaded so it lines up with the displayed time.
    always_ff @(posedge _1KHz) begin
        if (Reset) begin
            Chime <= 1'b0;
        end else begin
            Chime <= (min_nxt == 8'h59) && (sec_nxt >= 8'h55) && !Pause;
        end
    end
`else
    assign Chime = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_bcd.sv
// tb_timekeeper_bcd: directed bench for timekeeper_bcd with a shortened prescaler.
`timescale 1ns/1ps
module tb_timekeeper_bcd;

    localparam int unsigned TD = 100;
    localparam int unsigned DB = 20;
`ifdef HOURLY_CHIME_EN
    localparam bit CHIME_ON = 1'b1;
`else
    localparam bit CHIME_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       adj_hour;
    logic       adj_min;
    logic       pause;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       sec_tick;
    logic       chime;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0] prev_h;
    logic [7:0] prev_m;
    logic [7:0] prev_s;

    int ticks_seen;
    int tick_at [3];
    int cnt;
    int first;

    logic [7:0] sec_tab [10] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
                                 8'h56, 8'h57, 8'h58, 8'h59, 8'h00};

    timekeeper_bcd #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
        ._1KHz   (clk),
        .Reset   (rst),
        .AdjHour (adj_hour),
        .AdjMin  (adj_min),
        .Pause   (pause),
        .Hour    (hour),
        .Minute  (minute),
        .Second  (second),
        .SecTick (sec_tick),
        .Chime   (chime)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if (k == 0) adj_min = 1'b1;
            else        adj_hour = 1'b1;
            step(30);
            adj_min  = 1'b0;
            adj_hour = 1'b0;
            step(30);
        end
    endtask

    task automatic wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < int'(TD) + 5 && !seen; i++) begin
            prev_h = hour;
            prev_m = minute;
            prev_s = second;
            step(1);
            if (sec_tick) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        adj_hour = 1'b0;
        adj_min  = 1'b0;
        pause    = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_hour", 32'(hour), 32'h00);
        chk("rst_min", 32'(minute), 32'h00);
        chk("rst_sec", 32'(second), 32'h00);
        chk("rst_tick", 32'(sec_tick), 32'd0);
        chk("rst_chime", 32'(chime), 32'd0);

        // Three seconds from reset.
        ticks_seen = 0;
        for (int i = 0; i < 3; i++) tick_at[i] = 0;
        for (int i = 1; i <= 3 * int'(TD); i++) begin
            step(1);
            if (sec_tick) begin
                if (ticks_seen < 3) tick_at[ticks_seen] = i;
                ticks_seen++;
            end
        end
        chk("tick_count", 32'(ticks_seen), 32'd3);
        chk("tick0_at", 32'(tick_at[0]), 32'(TD));
        chk("tick1_at", 32'(tick_at[1]), 32'(2 * TD));
        chk("tick2_at", 32'(tick_at[2]), 32'(3 * TD));
        chk("sec_after3", 32'(second), 32'h03);

        // Pause mid-second: prescaler holds at 30, resumes with 70 edges left.
        step(30);
        chk("sec_prepause", 32'(second), 32'h03);
        pause = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2500; i++) begin
            step(1);
            if (sec_tick) cnt++;
        end
        chk("pause_ticks", 32'(cnt), 32'd0);
        chk("pause_sec", 32'(second), 32'h03);
        pause = 1'b0;
        first = 0;
        for (int i = 1; i <= 200 && first == 0; i++) begin
            step(1);
            if (sec_tick) first = i;
        end
        chk("resume_tick_at", 32'(first), 32'd70);
        chk("resume_sec", 32'(second), 32'h04);
        pause = 1'b1;

        // Bouncy minute key, then held: one increment at DB+3 after last edge.
        adj_min = 1'b1; step(1);
        adj_min = 1'b0; step(1);
        adj_min = 1'b1; step(1);
        adj_min = 1'b0; step(1);
        adj_min = 1'b1;
        step(DB + 2);
        chk("bounce_before", 32'(minute), 32'h00);
        step(1);
        chk("bounce_at", 32'(minute), 32'h01);
        step(100 - DB - 3);
        chk("bounce_hold", 32'(minute), 32'h01);
        adj_min = 1'b0;
        step(30);

        // Minute adjust to 59, then 59 -> 00 with no carry into Hour.
        press(0, 58);
        chk("min_59", 32'(minute), 32'h59);
        press(0, 1);
        chk("min_wrap", 32'(minute), 32'h00);
        chk("min_wrap_hour", 32'(hour), 32'h00);
        chk("min_wrap_sec", 32'(second), 32'h04);

        press(1, 9);
        chk("hour_09", 32'(hour), 32'h09);

        // Hour pending flag sets on the prescaler's last cycle (presc held at 0).
        pause = 1'b0;
        step(int'(TD) - int'(DB) - 3);
        adj_hour = 1'b1;
        step(DB + 2);
        chk("coin_hour_pre", 32'(hour), 32'h09);
        chk("coin_sec_pre", 32'(second), 32'h04);
        step(1);
        chk("coin_sec_tick", 32'(second), 32'h05);
        chk("coin_tick", 32'(sec_tick), 32'd1);
        chk("coin_hour_hold", 32'(hour), 32'h09);
        step(1);
        chk("coin_hour_10", 32'(hour), 32'h10);
        chk("coin_sec_keep", 32'(second), 32'h05);
        pause = 1'b1;
        adj_hour = 1'b0;
        step(30);

        // Chime window approaching 13:00:00.
        press(1, 2);
        chk("hour_12", 32'(hour), 32'h12);
        press(0, 59);
        chk("min_59b", 32'(minute), 32'h59);
        chk("sec_05", 32'(second), 32'h05);
        pause = 1'b0;
        for (int i = 0; i < 45; i++) wait_tick("run_to_50");
        chk("sec_50", 32'(second), 32'h50);
        chk("chime_50", 32'(chime), 32'd0);
        for (int i = 0; i < 10; i++) begin
            wait_tick("chime_tick");
            chk("chime_sec", 32'(second), 32'(sec_tab[i]));
            chk("chime_lvl", 32'(chime), 32'(CHIME_ON && (sec_tab[i] >= 8'h55)));
        end
        chk("hour_13", 32'(hour), 32'h13);
        chk("min_00", 32'(minute), 32'h00);

        // Preload 23:59:58 and wrap.
        pause = 1'b1;
        press(1, 10);
        press(0, 59);
        chk("pre_hour", 32'(hour), 32'h23);
        chk("pre_min", 32'(minute), 32'h59);
        pause = 1'b0;
        for (int i = 0; i < 58; i++) wait_tick("run_to_58");
        chk("t58_hour", 32'(hour), 32'h23);
        chk("t58_min", 32'(minute), 32'h59);
        chk("t58_sec", 32'(second), 32'h58);
        chk("t58_chime", 32'(chime), 32'(CHIME_ON));
        wait_tick("tick_59");
        chk("t59_sec", 32'(second), 32'h59);
        wait_tick("tick_wrap");
        chk("wrap_prev", {8'h0, prev_h, prev_m, prev_s}, 32'h00235959);
        chk("wrap_now", {8'h0, hour, minute, second}, 32'h00000000);
        chk("wrap_chime", 32'(chime), 32'd0);

        // Reset while a key is held: no increment until released and pressed again.
        pause = 1'b1;
        adj_min = 1'b1;
        step(5);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("rst2_time", {8'h0, hour, minute, second}, 32'h00000000);
        chk("rst2_tick", 32'(sec_tick), 32'd0);
        step(100);
        chk("rst2_held", 32'(minute), 32'h00);
        adj_min = 1'b0;
        step(40);
        press(0, 1);
        chk("rst2_press", 32'(minute), 32'h01);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
